lab9_soc_sysid_checker: RTL and testbench



---
 rtl/lab9_soc_sysid_checker_if.sv | 42 ++++
 rtl/lab9_soc_sysid_checker.sv | 250 +++++++++++++++++++++++++
 tb/tb_lab9_soc_sysid_checker.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lab9_soc_sysid_checker_if.sv
// -----------------------------------------------------------------------------
// lab9_soc_sysid_checker_if
//
// Avalon-MM read-only bus between the system-ID checker (master) and the
// system-ID slave on the lab9 SoC interconnect.
//
// Signals:
//   address        master -> slave  word select (0 = system ID, 1 = timestamp)
//   read           master -> slave  read request
//   waitrequest    slave  -> master stall; the request is taken when low
//   readdata       slave  -> master read data
//   readdatavalid  slave  -> master qualifies readdata
//
// Modports:
//   master  used by lab9_soc_sysid_checker
//   slave   used by the system-ID slave or a bench model of it
// -----------------------------------------------------------------------------
interface lab9_soc_sysid_checker_if #(
  parameter int DATA_W = 32
);
  logic              address;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdata,
    output readdatavalid
  );
endinterface

// File: rtl/lab9_soc_sysid_checker.sv
// -----------------------------------------------------------------------------
// lab9_soc_sysid_checker
//
// Avalon-MM read master that checks the lab9 system-ID slave. A start pulse
// launches a sequence that reads word 0 (system ID) and then word 1 (build
// timestamp), one outstanding read at a time. Each word is compared against a
// parameter. The result is reported as match/mismatch flags, or as a timeout
// when a read does not complete within TIMEOUT_CYCLES.
//
// Parameters:
//   DATA_W          bus data width (32 for the lab9 system-ID slave)
//   EXPECTED_ID     expected value of word 0
//   EXPECTED_TS     expected value of word 1
//   TIMEOUT_CYCLES  cycles allowed per read transaction, 1..65535
//
// Ports:
//   clock     single clock
//   reset     synchronous, active-high; abandons any sequence in progress
//   start     one-cycle pulse; begins a sequence when not busy
//   avm       Avalon-MM master side (address, read, waitrequest, readdata,
//             readdatavalid)
//   busy      sequence in progress
//   done      one-cycle pulse when the sequence ends
//   id_ok     captured word 0 equals EXPECTED_ID
//   ts_ok     captured word 1 equals EXPECTED_TS
//   timeout   sequence ended because a read timed out
//   id_value  captured word 0
//   ts_value  captured word 1
//   retries   (SYSID_CHECKER_RETRY_EN only) retries used in this sequence
//
// Build option:
//   SYSID_CHECKER_RETRY_EN  when defined, a timed-out word is re-read up to
//                           two more times before the sequence gives up, and
//                           the retries port is present. When undefined, the
//                           first timeout ends the sequence.
// -----------------------------------------------------------------------------
module lab9_soc_sysid_checker #(
  parameter int                 DATA_W         = 32,
  parameter logic [DATA_W-1:0]  EXPECTED_ID    = 32'd0,
  parameter logic [DATA_W-1:0]  EXPECTED_TS    = 32'd1522186126,
  parameter int unsigned        TIMEOUT_CYCLES = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  lab9_soc_sysid_checker_if.master   avm,
  output logic                       busy,
  output logic                       done,
  output logic                       id_ok,
  output logic                       ts_ok,
  output logic                       timeout,
  output logic [DATA_W-1:0]          id_value,
  output logic [DATA_W-1:0]          ts_value
`ifdef SYSID_CHECKER_RETRY_EN
  ,
  output logic [1:0]                 retries
`endif
);

  localparam int          CNT_W = 16;
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    WT_ID = 3'd2,
    RD_TS = 3'd3,
    WT_TS = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic                id_ok_nxt;
  logic                ts_ok_nxt;
  logic                timeout_nxt;
  logic [DATA_W-1:0]   id_value_nxt;
  logic [DATA_W-1:0]   ts_value_nxt;
  logic                in_tx;
  logic                tmo_hit;
  logic                fail;
  logic                give_up;
`ifdef SYSID_CHECKER_RETRY_EN
  logic [1:0]          attempt;
  logic [1:0]          attempt_nxt;
  logic [1:0]          retries_nxt;
`endif

  // The request is driven straight from the state so it rises the cycle after
  // start is sampled and the address cannot move while read is held.
  assign avm.read    = (state == RD_ID) || (state == RD_TS);
  assign avm.address = (state == RD_TS) || (state == WT_TS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
`ifdef SYSID_CHECKER_RETRY_EN
      attempt  <= '0;
      retries  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      id_ok    <= id_ok_nxt;
      ts_ok    <= ts_ok_nxt;
      timeout  <= timeout_nxt;
      id_value <= id_value_nxt;
      ts_value <= ts_value_nxt;
`ifdef SYSID_CHECKER_RETRY_EN
      attempt  <= attempt_nxt;
      retries  <= retries_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    id_ok_nxt    = id_ok;
    ts_ok_nxt    = ts_ok;
    timeout_nxt  = timeout;
    id_value_nxt = id_value;
    ts_value_nxt = ts_value;
    fail         = 1'b0;
    give_up      = 1'b0;
`ifdef SYSID_CHECKER_RETRY_EN
    attempt_nxt  = attempt;
    retries_nxt  = retries;
`endif

    in_tx   = (state == RD_ID) || (state == WT_ID) ||
              (state == RD_TS) || (state == WT_TS);
    // The counter starts at 0 on entry to RD_x, so it equals the limit exactly
    // TIMEOUT_CYCLES cycles after the read was first presented.
    tmo_hit = in_tx && (cnt == TMO_LIMIT);

    if (in_tx) begin
      cnt_nxt = cnt + 1'b1;
    end

    unique case (state)
      IDLE, FIN: begin
        if (start) begin
          state_nxt    = RD_ID;
          cnt_nxt      = '0;
          busy_nxt     = 1'b1;
          id_ok_nxt    = 1'b0;
          ts_ok_nxt    = 1'b0;
          timeout_nxt  = 1'b0;
          id_value_nxt = '0;
          ts_value_nxt = '0;
`ifdef SYSID_CHECKER_RETRY_EN
          attempt_nxt  = '0;
          retries_nxt  = '0;
`endif
        end
      end

      RD_ID: begin
        // A request taken on the limit cycle has not returned data, so the
        // timeout takes priority over acceptance here.
        if (tmo_hit) begin
          fail = 1'b1;
        end else if (!avm.waitrequest) begin
          state_nxt = WT_ID;
        end
      end

      WT_ID: begin
        // Data arriving on the limit cycle still counts as a completed read.
        if (avm.readdatavalid) begin
          id_value_nxt = avm.readdata;
          id_ok_nxt    = (avm.readdata == EXPECTED_ID);
          state_nxt    = RD_TS;
          cnt_nxt      = '0;
`ifdef SYSID_CHECKER_RETRY_EN
          attempt_nxt  = '0;
`endif
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end

      RD_TS: begin
        if (tmo_hit) begin
          fail = 1'b1;
        end else if (!avm.waitrequest) begin
          state_nxt = WT_TS;
        end
      end

      WT_TS: begin
        if (avm.readdatavalid) begin
          ts_value_nxt = avm.readdata;
          ts_ok_nxt    = (avm.readdata == EXPECTED_TS);
          state_nxt    = FIN;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
        end else if (tmo_hit) begin
          fail = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

`ifdef SYSID_CHECKER_RETRY_EN
    // Third failed attempt on a word ends the sequence; earlier ones restart
    // that word with a fresh counter.
    give_up = fail && (attempt == 2'd2);
    if (fail && !give_up) begin
      state_nxt   = ((state == RD_TS) || (state == WT_TS)) ? RD_TS : RD_ID;
      cnt_nxt     = '0;
      attempt_nxt = attempt + 2'd1;
      if (retries != 2'd3) begin
        retries_nxt = retries + 2'd1;
      end
    end
`else
    give_up = fail;
`endif

    if (give_up) begin
      timeout_nxt = 1'b1;
      state_nxt   = FIN;
      busy_nxt    = 1'b0;
      done_nxt    = 1'b1;
    end
  end

endmodule

// File: tb/tb_lab9_soc_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_lab9_soc_sysid_checker
//
// Bench for lab9_soc_sysid_checker. The bench plays the system-ID slave with a
// per-word stall count, read latency and an optional "never answer" flag. The
// expected end cycle and status are computed from those per-word figures with
// plain arithmetic: a word completes when stall + latency fits in the timeout
// window, otherwise each attempt costs TIMEOUT_CYCLES + 1 cycles.
// -----------------------------------------------------------------------------
module tb_lab9_soc_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1522186126;
  localparam int          TMO    = 8;
`ifdef SYSID_CHECKER_RETRY_EN
  localparam int          ATTEMPTS = 3;
`else
  localparam int          ATTEMPTS = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;
`ifdef SYSID_CHECKER_RETRY_EN
  logic [1:0]  retries;
`endif

  int n_chk = 0;
  int n_err = 0;

  lab9_soc_sysid_checker_if #(.DATA_W(32)) avm ();

  lab9_soc_sysid_checker #(
    .DATA_W         (32),
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .avm      (avm.master),
    .busy     (busy),
    .done     (done),
    .id_ok    (id_ok),
    .ts_ok    (ts_ok),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
`ifdef SYSID_CHECKER_RETRY_EN
    ,
    .retries  (retries)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/busy"},     busy,     0);
    chk({tag, "/done"},     done,     0);
    chk({tag, "/id_ok"},    id_ok,    0);
    chk({tag, "/ts_ok"},    ts_ok,    0);
    chk({tag, "/timeout"},  timeout,  0);
    chk({tag, "/id_value"}, id_value, 0);
    chk({tag, "/ts_value"}, ts_value, 0);
    chk({tag, "/read"},     avm.read, 0);
    chk({tag, "/address"},  avm.address, 0);
`ifdef SYSID_CHECKER_RETRY_EN
    chk({tag, "/retries"},  retries,  0);
`endif
  endtask

  // One check sequence. w/l = stall cycles and read latency per word, dr =
  // slave never answers that word, d = data per word. skip_start: start was
  // already raised in the previous sequence's done cycle. b2b: raise start in
  // this sequence's done cycle. restart_at: extra start pulse while busy.
  // reset_at: assert reset in that cycle and then watch that nothing happens.
  task automatic run_seq(input string tag,
                         input int w0, input int l0, input int w1, input int l1,
                         input bit dr0, input bit dr1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input bit skip_start, input bit b2b,
                         input int restart_at, input int reset_at);
    int          t;
    logic [31:0] e_idv, e_tsv;
    bit          e_idok, e_tsok, e_tmo;
    int          e_retries;
    int          cyc;
    int          stall;
    bit          pend;
    int          due;
    logic [31:0] pdata;
    bit          in_read;
    logic        first_addr;
    bit          seen;

    // Reference outcome
    t = 1; e_idv = 0; e_tsv = 0; e_idok = 0; e_tsok = 0; e_tmo = 0; e_retries = 0;
    if (!dr0 && (w0 + l0 <= TMO)) begin
      t      += w0 + l0 + 1;
      e_idv  = d0;
      e_idok = (d0 == EXP_ID);
      if (!dr1 && (w1 + l1 <= TMO)) begin
        t      += w1 + l1 + 1;
        e_tsv  = d1;
        e_tsok = (d1 == EXP_TS);
      end else begin
        t         += ATTEMPTS * (TMO + 1);
        e_tmo     = 1;
        e_retries = ATTEMPTS - 1;
      end
    end else begin
      t         += ATTEMPTS * (TMO + 1);
      e_tmo     = 1;
      e_retries = ATTEMPTS - 1;
    end

    stall = 0; pend = 0; due = 0; pdata = 0; in_read = 0; first_addr = 0;
    seen = 0; cyc = 0;

    if (!skip_start) begin
      @(negedge clock);
      start = 1'b1;
    end

    while (cyc < 200 && !seen) begin
      @(negedge clock);
      cyc++;
      start = (cyc == restart_at);
      reset = (reset_at != 0) && (cyc == reset_at);

      if (cyc == 1) begin
        chk({tag, "/c1_read"},     avm.read,    1);
        chk({tag, "/c1_address"},  avm.address, 0);
        chk({tag, "/c1_busy"},     busy,        1);
        chk({tag, "/c1_done"},     done,        0);
        chk({tag, "/c1_id_value"}, id_value,    0);
        chk({tag, "/c1_ts_value"}, ts_value,    0);
        chk({tag, "/c1_flags"},    {id_ok, ts_ok, timeout}, 0);
      end
      chk({tag, "/read_when_idle"}, avm.read & ~busy, 0);

      if (reset_at != 0 && cyc == reset_at + 1) chk_all_zero({tag, "/after_reset"});
      if (reset_at != 0 && cyc == reset_at + 4) begin
        chk_all_zero({tag, "/late_valid"});
        seen = 1;
      end

      // Slave behaviour for this cycle
      avm.readdatavalid = 1'b0;
      avm.readdata      = $urandom;
      if (pend && due == cyc) begin
        avm.readdatavalid = 1'b1;
        avm.readdata      = pdata;
        pend              = 0;
      end
      if (avm.read) begin
        if (!in_read) begin
          in_read    = 1;
          first_addr = avm.address;
        end
        if (stall < (avm.address ? w1 : w0)) begin
          avm.waitrequest = 1'b1;
          stall++;
        end else begin
          avm.waitrequest = 1'b0;
          chk({tag, "/addr_stable"}, avm.address, first_addr);
          in_read = 0;
          stall   = 0;
          if (!(avm.address ? dr1 : dr0)) begin
            pend  = 1;
            due   = cyc + (avm.address ? l1 : l0);
            pdata = avm.address ? d1 : d0;
          end
        end
      end else begin
        avm.waitrequest = 1'b0;
        stall           = 0;
        in_read         = 0;
      end

      if (done && reset_at == 0) begin
        seen = 1;
        chk({tag, "/done_cycle"}, cyc,      t);
        chk({tag, "/busy"},       busy,     0);
        chk({tag, "/id_value"},   id_value, e_idv);
        chk({tag, "/ts_value"},   ts_value, e_tsv);
        chk({tag, "/id_ok"},      id_ok,    e_idok);
        chk({tag, "/ts_ok"},      ts_ok,    e_tsok);
        chk({tag, "/timeout"},    timeout,  e_tmo);
`ifdef SYSID_CHECKER_RETRY_EN
        chk({tag, "/retries"},    retries,  e_retries);
`endif
        if (b2b) start = 1'b1;
      end
    end

    if (!seen) chk({tag, "/done_within_budget"}, 0, 1);
    avm.waitrequest   = 1'b0;
    avm.readdatavalid = 1'b0;
    if (!b2b) begin
      @(negedge clock);
      chk({tag, "/done_one_cycle"}, done, 0);
      if (reset_at == 0) begin
        chk({tag, "/hold_id_value"}, id_value, e_idv);
        chk({tag, "/hold_ts_value"}, ts_value, e_tsv);
        chk({tag, "/hold_flags"},    {id_ok, ts_ok, timeout}, {e_idok, e_tsok, e_tmo});
      end
    end
  endtask

  initial begin
    int  w0, l0, w1, l1;
    bit  dr0, dr1, b2b, prev_b2b;
    logic [31:0] d0, d1;

    reset             = 1'b1;
    start             = 1'b0;
    avm.waitrequest   = 1'b0;
    avm.readdatavalid = 1'b0;
    avm.readdata      = '0;
    repeat (2) @(negedge clock);
    chk_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clock);

    run_seq("nominal",  0, 1, 0, 1, 0, 0, EXP_ID, EXP_TS, 0, 0, 0, 0);
    run_seq("mismatch", 0, 1, 0, 1, 0, 0, EXP_ID, 32'd1,  0, 0, 0, 0);
    run_seq("stall",    4, 3, 4, 3, 0, 0, EXP_ID, EXP_TS, 0, 0, 3, 0);
    run_seq("tmo_id",   0, 1, 0, 1, 1, 0, EXP_ID, EXP_TS, 0, 0, 0, 0);
    run_seq("tmo_ts",   2, 2, 0, 1, 0, 1, 32'h1234, EXP_TS, 0, 0, 0, 0);
    run_seq("edge",     4, 4, 0, 1, 0, 0, EXP_ID, EXP_TS, 0, 0, 0, 0);
    run_seq("reset",    0, 1, 0, 3, 0, 0, EXP_ID, EXP_TS, 0, 0, 0, 4);
    run_seq("b2b_a",    1, 2, 0, 1, 0, 0, EXP_ID, 32'hDEAD_BEEF, 0, 1, 0, 0);
    run_seq("b2b_b",    0, 1, 2, 3, 0, 0, EXP_ID, EXP_TS, 1, 0, 0, 0);

    prev_b2b = 0;
    for (int i = 0; i < 40; i++) begin
      w0  = $urandom_range(0, 4);
      l0  = $urandom_range(1, 4);
      w1  = $urandom_range(0, 4);
      l1  = $urandom_range(1, 4);
      dr0 = ($urandom_range(0, 7) == 0);
      dr1 = ($urandom_range(0, 7) == 0);
      d0  = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      d1  = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      b2b = (i != 39) && ($urandom_range(0, 3) == 0);
      run_seq($sformatf("rnd%0d", i), w0, l0, w1, l1, dr0, dr1, d0, d1,
              prev_b2b, b2b, 0, 0);
      prev_b2b = b2b;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
